sd_crc_engine: RTL

SD_CRC_ENGINE -- requirements
Module: sd_crc_engine

---
 rtl/sd_crc_pkg.sv | 39 +++
 rtl/sd_crc_lane.sv | 43 ++++
 rtl/sd_crc_engine.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sd_crc_pkg.sv
// sd_crc_pkg: shared types and constants for the SD CRC engine.
// Holds the FSM state encoding, CRC lengths, polynomial taps and lane masks.
// Optional feature macro used by the engine: SD_CRC_CHECK_EN.
package sd_crc_pkg;

  // Frame sequencing states of the engine
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Number of CRC bits emitted per lane
  localparam int CRC7_LEN  = 7;
  localparam int CRC16_LEN = 16;

  // MSB position of each CRC inside the shared 16-bit lane register
  localparam int CRC7_MSB  = 6;
  localparam int CRC16_MSB = 15;

  // Galois feedback taps (x^7+x^3+1 and x^16+x^12+x^5+1, leading term dropped)
  localparam logic [15:0] CRC7_TAPS  = 16'h0009;
  localparam logic [15:0] CRC16_TAPS = 16'h1021;

  // Register bits that belong to each CRC width
  localparam logic [15:0] CRC7_MASK  = 16'h007F;
  localparam logic [15:0] CRC16_MASK = 16'hFFFF;

  // mode encoding: 0 = CRC16, 1 = CRC7
  localparam logic MODE_CRC16 = 1'b0;
  localparam logic MODE_CRC7  = 1'b1;

  // Number of CRC bits for a given mode, sized to the 5-bit bit counter
  function automatic logic [4:0] crc_len(input logic i_mode);
    crc_len = (i_mode == MODE_CRC7) ? 5'(CRC7_LEN) : 5'(CRC16_LEN);
  endfunction

endpackage

// File: rtl/sd_crc_lane.sv
// sd_crc_lane: one serial CRC LFSR for a single SD data lane.
// A 16-bit register holds either a CRC16 (all bits) or a CRC7 (bits 6:0).
// Accumulates one payload bit per update, then shifts the CRC out MSB first.
module sd_crc_lane
  import sd_crc_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic i_clear,
  input  logic i_update,
  input  logic i_shift,
  input  logic i_mode,
  input  logic i_din,
  output logic o_msb
);

  logic [15:0] r_lfsr;
  logic [15:0] w_mask;
  logic [15:0] w_taps;
  logic [15:0] w_base;
  logic        w_fb;

  // Select width-dependent constants and form the feedback bit
  always_comb begin
    w_mask = (i_mode == MODE_CRC7) ? CRC7_MASK : CRC16_MASK;
    w_taps = (i_mode == MODE_CRC7) ? CRC7_TAPS : CRC16_TAPS;
    o_msb  = (i_mode == MODE_CRC7) ? r_lfsr[CRC7_MSB] : r_lfsr[CRC16_MSB];
    w_fb   = i_din ^ o_msb;
    w_base = {r_lfsr[14:0], 1'b0};
  end

  // LFSR register: clear, Galois update, or plain shift-out; clear wins
  always_ff @(posedge CLK) begin
    if (RST || i_clear) begin
      r_lfsr <= '0;
    end else if (i_update) begin
      r_lfsr <= (w_base ^ (w_fb ? w_taps : 16'h0000)) & w_mask;
    end else if (i_shift) begin
      r_lfsr <= w_base & w_mask;
    end
  end

endmodule

// File: rtl/sd_crc_engine.sv
// sd_crc_engine: multi-lane SD CRC7/CRC16 generator with serial CRC output.
// Flow: start clears lanes, payload accumulates while din_valid, the bit
// flagged with last closes the frame, then the CRC shifts out under
// dout_valid/dout_ready and crc_done pulses for one cycle.
// Handshake: a CRC bit transfers on a rising edge where dout_valid and
// dout_ready are both high; dout holds steady while dout_ready is low.
// Optional feature macro: SD_CRC_CHECK_EN adds crc_rx/crc_ok comparison of a
// received CRC against the generated one.
module sd_crc_engine
  import sd_crc_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             mode,
  input  logic             din_valid,
  input  logic [LANES-1:0] din,
  input  logic             last,
  input  logic             dout_ready,
  output logic             dout_valid,
  output logic [LANES-1:0] dout,
  output logic             busy,
  output logic             crc_done
`ifdef SD_CRC_CHECK_EN
  ,
  input  logic [LANES-1:0] crc_rx,
  output logic             crc_ok
`endif
);

  state_t           r_state;
  logic             r_mode;
  logic [4:0]       r_cnt;
  logic             r_dout_valid;
  logic             r_busy;
  logic             r_crc_done;

  logic             w_accept;
  logic             w_update;
  logic             w_shift;
  logic             w_last_bit;
  logic [4:0]       w_len_m1;
  logic [LANES-1:0] w_msb;

  // Datapath strobes; a start pulse overrides any update or shift that cycle
  always_comb begin
    w_len_m1   = crc_len(r_mode) - 5'd1;
    w_accept   = (r_state == ST_SHIFT) && dout_ready;
    w_last_bit = w_accept && (r_cnt == w_len_m1);
    w_update   = (r_state == ST_ACCUM) && din_valid && !start;
    w_shift    = w_accept && !start;
  end

  // One LFSR per lane; in CRC7 only lane 0 accumulates payload
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic w_lane_upd;
    if (g == 0) begin : g_primary
      assign w_lane_upd = w_update;
    end else begin : g_secondary
      assign w_lane_upd = w_update && (r_mode == MODE_CRC16);
    end

    sd_crc_lane u_lane (
      .CLK      (CLK),
      .RST      (RST),
      .i_clear  (start),
      .i_update (w_lane_upd),
      .i_shift  (w_shift),
      .i_mode   (r_mode),
      .i_din    (din[g]),
      .o_msb    (w_msb[g])
    );
  end

  // Frame FSM with registered status outputs; RST beats start beats the rest
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_mode       <= MODE_CRC16;
      r_cnt        <= '0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_crc_done   <= 1'b0;
    end else if (start) begin
      r_state      <= ST_ACCUM;
      r_mode       <= mode;
      r_cnt        <= '0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b1;
      r_crc_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_dout_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_crc_done   <= 1'b0;
        end
        ST_ACCUM: begin
          if (din_valid && last) begin
            r_state      <= ST_SHIFT;
            r_cnt        <= '0;
            r_dout_valid <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (w_last_bit) begin
            r_state      <= ST_DONE;
            r_dout_valid <= 1'b0;
            r_crc_done   <= 1'b1;
            r_cnt        <= r_cnt + 5'd1;
          end else if (w_accept) begin
            r_cnt        <= r_cnt + 5'd1;
          end
        end
        ST_DONE: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_crc_done <= 1'b0;
          r_cnt      <= '0;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_dout_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_crc_done   <= 1'b0;
        end
      endcase
    end
  end

  // Present lane MSBs only while shifting; unused lanes stay 0 in CRC7
  always_comb begin
    dout = '0;
    if (r_dout_valid) begin
      if (r_mode == MODE_CRC7) begin
        dout[0] = w_msb[0];
      end else begin
        dout = w_msb;
      end
    end
  end

  assign dout_valid = r_dout_valid;
  assign busy       = r_busy;
  assign crc_done   = r_crc_done;

`ifdef SD_CRC_CHECK_EN
  logic r_match;
  logic r_crc_ok;
  logic w_bit_ok;

  // Compare each accepted CRC bit against the received one on active lanes
  always_comb begin
    if (r_mode == MODE_CRC7) begin
      w_bit_ok = (crc_rx[0] == dout[0]);
    end else begin
      w_bit_ok = (crc_rx == dout);
    end
  end

  // Sticky all-bits-matched flag; crc_ok is asserted only during DONE
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_match  <= 1'b1;
      r_crc_ok <= 1'b0;
    end else if (start) begin
      r_match  <= 1'b1;
      r_crc_ok <= 1'b0;
    end else if (w_accept) begin
      r_match  <= r_match & w_bit_ok;
      r_crc_ok <= w_last_bit ? (r_match & w_bit_ok) : 1'b0;
    end else begin
      r_crc_ok <= 1'b0;
    end
  end

  assign crc_ok = r_crc_ok;
`endif

endmodule
